// File: rtl/tinycore_bus_mem.sv
// tinycore_bus_mem: memory-side responder for the tinycore CPU bus.
// Holds program/data RAM, fills it from a byte-stream loader while the core
// is held in reset, then releases the core and serves its reads and writes.
// Optional feature macro: TINYCORE_MEM_PROTECT_EN makes the loaded image
// read-only in RUN and pulses wp_fault on every blocked write.
module tinycore_bus_mem #(
    parameter int ADDR_SZ   = 8,
    parameter int DATA_SZ   = 8,
    parameter int MEM_DEPTH = 1 << ADDR_SZ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_SZ-1:0] addr,
    input  logic [DATA_SZ-1:0] data_i,
    input  logic               we,
    output logic [DATA_SZ-1:0] data_o,
    input  logic               ld_valid,
    input  logic [DATA_SZ-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               core_reset_n,
    output logic               ld_ovf,
    output logic               wp_fault
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    // Index width of the implemented array; out-of-range addresses are
    // filtered before indexing so the low bits never alias.
    localparam int                 IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SZ:0]   DEPTH_EXT = (ADDR_SZ + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SZ-1:0] LAST_PTR  = ADDR_SZ'(MEM_DEPTH - 1);

    logic [DATA_SZ-1:0] mem [MEM_DEPTH];

    state_t             state_q, state_d;
    logic [ADDR_SZ-1:0] ld_ptr_q, ld_ptr_d;
    logic               ld_ovf_q, ld_ovf_d;
    logic [DATA_SZ-1:0] data_o_q, data_o_d;
    logic               core_reset_n_q, core_reset_n_d;

    logic               xfer;
    logic               addr_in_range;
    logic               wr_blocked;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [DATA_SZ-1:0] mem_wdata;

    assign xfer          = ld_valid && ld_ready;
    assign addr_in_range = ({1'b0, addr} < DEPTH_EXT);

`ifdef TINYCORE_MEM_PROTECT_EN
    logic [ADDR_SZ:0] prog_len_q, prog_len_d;
    logic             wp_fault_q;

    assign wr_blocked = (state_q == RUN) && we && addr_in_range
                        && ({1'b0, addr} < prog_len_q);

    // Capture the image length on the transfer that ends the load
    always_comb begin
        prog_len_d = prog_len_q;
        if ((state_q == LOAD) && xfer && (ld_last || (ld_ptr_q == LAST_PTR))) begin
            prog_len_d = {1'b0, ld_ptr_q} + (ADDR_SZ + 1)'(1);
        end
    end

    // Image length and write-protect fault pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_len_q <= '0;
            wp_fault_q <= 1'b0;
        end else begin
            prog_len_q <= prog_len_d;
            wp_fault_q <= wr_blocked;
        end
    end

    assign wp_fault = wp_fault_q;
`else
    assign wr_blocked = 1'b0;
    assign wp_fault   = 1'b0;
`endif

    // State register plus loader pointer, overflow flag and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LOAD;
            ld_ptr_q       <= '0;
            ld_ovf_q       <= 1'b0;
            data_o_q       <= '0;
            core_reset_n_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ld_ptr_q       <= ld_ptr_d;
            ld_ovf_q       <= ld_ovf_d;
            data_o_q       <= data_o_d;
            core_reset_n_q <= core_reset_n_d;
        end
    end

    // Next-state: load until ld_last or the array is full, one release cycle, then run
    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        ld_ovf_d = ld_ovf_q;
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    if (ld_last) begin
                        state_d = RELEASE;
                    end else if (ld_ptr_q == LAST_PTR) begin
                        state_d  = RELEASE;
                        ld_ovf_d = 1'b1;
                    end
                    if (ld_ptr_q != LAST_PTR) begin
                        ld_ptr_d = ld_ptr_q + ADDR_SZ'(1);
                    end
                end
            end
            RELEASE: state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = LOAD;
        endcase
    end

    // Outputs: loader handshake, core release, read data and RAM write port select
    always_comb begin
        ld_ready       = (state_q == LOAD) && !reset;
        core_reset_n_d = (state_d == RUN);
        data_o_d       = '0;
        mem_we         = 1'b0;
        mem_waddr      = ld_ptr_q[IDX_W-1:0];
        mem_wdata      = ld_data;
        case (state_q)
            LOAD: begin
                mem_we = xfer;
            end
            RUN: begin
                if (addr_in_range) begin
                    data_o_d = mem[addr[IDX_W-1:0]];
                end
                if (we && addr_in_range && !wr_blocked && !reset) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr[IDX_W-1:0];
                    mem_wdata = data_i;
                end
            end
            default: ;
        endcase
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_o       = data_o_q;
    assign core_reset_n = core_reset_n_q;
    assign ld_ovf       = ld_ovf_q;

endmodule

// File: tb/tb_tinycore_bus_mem.sv
// tb_tinycore_bus_mem: directed bench for tinycore_bus_mem.
// Instance A uses the full 256-word array, instance B a 16-word array so the
// overflow and out-of-range paths can be exercised. dsel picks which one the
// shared stimulus drives and which one is observed.
module tb_tinycore_bus_mem;

`ifdef TINYCORE_MEM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, dsel, ld_valid, ld_last, we;
    logic [7:0] ld_data, addr, data_i;

    logic       a_reset, a_valid, a_we, b_reset, b_valid, b_we;
    logic [7:0] a_data_o, b_data_o;
    logic       a_ready, a_crn, a_ovf, a_wpf;
    logic       b_ready, b_crn, b_ovf, b_wpf;

    logic [7:0] cur_data_o;
    logic       cur_ready, cur_crn, cur_ovf, cur_wpf;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign a_reset = rst & ~dsel;
    assign a_valid = ld_valid & ~dsel;
    assign a_we    = we & ~dsel;
    assign b_reset = rst & dsel;
    assign b_valid = ld_valid & dsel;
    assign b_we    = we & dsel;

    assign cur_data_o = dsel ? b_data_o : a_data_o;
    assign cur_ready  = dsel ? b_ready  : a_ready;
    assign cur_crn    = dsel ? b_crn    : a_crn;
    assign cur_ovf    = dsel ? b_ovf    : a_ovf;
    assign cur_wpf    = dsel ? b_wpf    : a_wpf;

    tinycore_bus_mem #(.ADDR_SZ(8), .DATA_SZ(8), .MEM_DEPTH(256)) dut_a (
        .clk(clk), .reset(a_reset), .addr(addr), .data_i(data_i), .we(a_we),
        .data_o(a_data_o), .ld_valid(a_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(a_ready), .core_reset_n(a_crn), .ld_ovf(a_ovf), .wp_fault(a_wpf)
    );

    tinycore_bus_mem #(.ADDR_SZ(8), .DATA_SZ(8), .MEM_DEPTH(16)) dut_b (
        .clk(clk), .reset(b_reset), .addr(addr), .data_i(data_i), .we(b_we),
        .data_o(b_data_o), .ld_valid(b_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(b_ready), .core_reset_n(b_crn), .ld_ovf(b_ovf), .wp_fault(b_wpf)
    );

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l);
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic checkRead(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        we   = 1'b0;
        tick();
        checkOutput(tag, cur_data_o, exp);
    endtask

    task automatic writeMem(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        data_i = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dsel = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; we = 1'b0;
        ld_data = 8'h00; addr = 8'h00; data_i = 8'h00;

        // ---- Reset state and basic 3-byte image on A ----
        tick();
        tick();
        checkOutput("rst_ld_ready", cur_ready, 1'b0);
        checkOutput("rst_core_reset_n", cur_crn, 1'b0);
        checkOutput("rst_data_o", cur_data_o, 8'h00);
        checkOutput("rst_ld_ovf", cur_ovf, 1'b0);
        checkOutput("rst_wp_fault", cur_wpf, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("load_ld_ready", cur_ready, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        checkOutput("load_mid_ready", cur_ready, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b1);
        ld_valid = 1'b0;
        checkOutput("release_ld_ready", cur_ready, 1'b0);
        checkOutput("release_core_held", cur_crn, 1'b0);
        addr = 8'h01;
        tick();
        checkOutput("run_core_released", cur_crn, 1'b1);
        checkOutput("run_first_data_o", cur_data_o, 8'h00);
        tick();
        checkOutput("run_read_addr1", cur_data_o, 8'h22);
        checkOutput("run_ld_ovf", cur_ovf, 1'b0);

        // ---- Read-during-write returns old data ----
        writeMem(8'h80, 8'h3C);
        addr = 8'h80; data_i = 8'hA5; we = 1'b1;
        tick();
        we = 1'b0;
        checkOutput("rdw_old_data", cur_data_o, 8'h3C);
        tick();
        checkOutput("rdw_new_data", cur_data_o, 8'hA5);

        // ---- Loader ignored in RUN ----
        ld_valid = 1'b1; ld_data = 8'hEE; ld_last = 1'b1;
        tick();
        checkOutput("run_ld_ready", cur_ready, 1'b0);
        tick();
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        checkRead("run_ignore_ld_m0", 8'h00, 8'h11);
        checkRead("run_ignore_ld_m2", 8'h02, 8'h33);

        // ---- Reset mid-load, then 1-byte image ----
        doReset();
        applyStimulus(1'b1, 8'hC1, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b0);
        rst = 1'b1; ld_valid = 1'b1; ld_data = 8'hC3;
        #1;
        checkOutput("midrst_ld_ready", cur_ready, 1'b0);
        tick();
        checkOutput("midrst_core_held", cur_crn, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h7E, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        checkOutput("reload_core_held", cur_crn, 1'b0);
        tick();
        checkOutput("reload_core_released", cur_crn, 1'b1);
        checkRead("reload_m0", 8'h00, 8'h7E);
        checkRead("reload_m1_partial", 8'h01, 8'hC2);
        checkRead("reload_m2_kept", 8'h02, 8'h33);

        // ---- Gapped 4-byte image, then protection behaviour ----
        doReset();
        applyStimulus(1'b1, 8'hA0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 1'b1);
        checkOutput("gap_still_loading", cur_ready, 1'b1);
        applyStimulus(1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b0, 8'hFE, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b1);
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        checkOutput("gap_core_released", cur_crn, 1'b1);
        checkRead("gap_m0", 8'h00, 8'hA0);
        checkRead("gap_m1", 8'h01, 8'hA1);
        checkRead("gap_m3", 8'h03, 8'hA3);
        writeMem(8'h02, 8'h99);
        checkOutput("prot_fault_pulse", cur_wpf, PROT);
        addr = 8'h02;
        tick();
        checkOutput("prot_fault_clears", cur_wpf, 1'b0);
        checkOutput("prot_m2", cur_data_o, PROT ? 8'hA2 : 8'h99);
        writeMem(8'h04, 8'h44);
        checkOutput("prot_free_nofault", cur_wpf, 1'b0);
        checkRead("prot_free_m4", 8'h04, 8'h44);

        // ---- Overflow on the 16-word instance ----
        dsel = 1'b1;
        doReset();
        checkOutput("b_rst_ovf", cur_ovf, 1'b0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
        end
        checkOutput("b_ovf_before_full", cur_ovf, 1'b0);
        checkOutput("b_ready_before_full", cur_ready, 1'b1);
        applyStimulus(1'b1, 8'h4F, 1'b0);
        ld_valid = 1'b0;
        checkOutput("b_ovf_set", cur_ovf, 1'b1);
        checkOutput("b_ready_full", cur_ready, 1'b0);
        tick();
        checkOutput("b_core_released", cur_crn, 1'b1);
        checkRead("b_m15", 8'h0F, 8'h4F);
        checkRead("b_oor_read", 8'h20, 8'h00);
        writeMem(8'h20, 8'h77);
        checkOutput("b_oor_nofault", cur_wpf, 1'b0);
        checkRead("b_oor_after_write", 8'h20, 8'h00);
        checkRead("b_m0_no_alias", 8'h00, 8'h40);
        checkOutput("b_ovf_sticky", cur_ovf, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
